eq_band_mixer: RTL and testbench

//  Downstream of the FIR equalizer filter bank. Captures the NUM_BANDS 48-bit band outputs per channel on the filter valid strobe.

---
 rtl/eq_mix_pkg.sv | 39 +++
 rtl/eq_mix_mac.sv | 62 ++++++
 rtl/eq_band_mixer.sv | 201 ++++++++++++++++++++
 tb/tb_eq_band_mixer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/eq_mix_pkg.sv
// Shared types, constants and the round/saturate helper for the EQ band mixer.
// Imported by the mixer top and its MAC datapath.
package eq_mix_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    DRAIN = 3'd2,
    ROUND = 3'd3,
    OUT   = 3'd4
  } mix_state_e;

  localparam logic [15:0] GAIN_UNITY = 16'h4000;
  localparam int          ACC_W      = 52;

  localparam logic signed [ACC_W:0] SAT_MAX = 53'sd8388607;
  localparam logic signed [ACC_W:0] SAT_MIN = -53'sd8388608;

  // Round-half-up by adding half an LSB before the arithmetic shift, then clamp to 24 bits.
  function automatic logic [23:0] sat_round24(input logic signed [ACC_W-1:0] acc,
                                               input int                     frac);
    logic signed [ACC_W:0] half;
    logic signed [ACC_W:0] r;
    logic        [23:0]    y;
    half = 53'sd1 <<< (frac - 1);
    r    = {acc[ACC_W-1], acc};
    r    = r + half;
    r    = r >>> frac;
    if (r > SAT_MAX) begin
      y = 24'h7FFFFF;
    end else if (r < SAT_MIN) begin
      y = 24'h800000;
    end else begin
      y = r[23:0];
    end
    return y;
  endfunction

endpackage

// File: rtl/eq_mix_mac.sv
// Time-shared multiplier with a registered product feeding separate L/R accumulators.
// sel_lr travels alongside the product so each result lands in the right channel.
module eq_mix_mac
  import eq_mix_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    sel_lr,
  input  logic signed [31:0]      x,
  input  logic signed [15:0]      gain,
  output logic signed [ACC_W-1:0] acc_l,
  output logic signed [ACC_W-1:0] acc_r
);

  logic signed [47:0]      x_ext_s;
  logic signed [47:0]      g_ext_s;
  logic signed [47:0]      prod_s;
  logic signed [47:0]      prod_r;
  logic                    prod_vld_r;
  logic                    prod_sel_r;
  logic signed [ACC_W-1:0] prod_ext_s;
  logic signed [ACC_W-1:0] acc_l_r;
  logic signed [ACC_W-1:0] acc_r_r;

  // Sign-extend both operands to the product width so the low 48 bits are exact.
  always_comb begin
    x_ext_s    = {{16{x[31]}}, x};
    g_ext_s    = {{32{gain[15]}}, gain};
    prod_s     = x_ext_s * g_ext_s;
    prod_ext_s = {{4{prod_r[47]}}, prod_r};
  end

  // Product stage and accumulators; clr starts a fresh mix.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      prod_r     <= 48'sd0;
      prod_vld_r <= 1'b0;
      prod_sel_r <= 1'b0;
      acc_l_r    <= 52'sd0;
      acc_r_r    <= 52'sd0;
    end else begin
      prod_vld_r <= en;
      prod_sel_r <= sel_lr;
      if (en) begin
        prod_r <= prod_s;
      end
      if (prod_vld_r) begin
        if (prod_sel_r) begin
          acc_r_r <= acc_r_r + prod_ext_s;
        end else begin
          acc_l_r <= acc_l_r + prod_ext_s;
        end
      end
    end
  end

  assign acc_l = acc_l_r;
  assign acc_r = acc_r_r;

endmodule

// File: rtl/eq_band_mixer.sv
// Captures per-band EQ filter outputs, applies per-band gains through one shared MAC,
// and produces rounded, saturated 24-bit L/R samples.
module eq_band_mixer
  import eq_mix_pkg::*;
#(
  parameter int NUM_BANDS  = 4,
  parameter int BAND_SHIFT = 15,
  parameter int GAIN_FRAC  = 14,
  localparam int SEL_W     = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    audio_en,
  input  logic                    in_valid,
  input  logic [NUM_BANDS*48-1:0] l_band_in,
  input  logic [NUM_BANDS*48-1:0] r_band_in,
  input  logic                    gain_wr_en,
  input  logic [SEL_W-1:0]        gain_select,
  input  logic [7:0]              gain_wr_msb,
  input  logic [7:0]              gain_wr_lsb,
  input  logic                    mute,
  input  logic                    overrun_clr,
  output logic [23:0]             l_data_out,
  output logic [23:0]             r_data_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int         K_W    = $clog2(2 * NUM_BANDS);
  localparam logic [K_W-1:0] K_LAST = K_W'(2 * NUM_BANDS - 1);

  mix_state_e              state_r;
  mix_state_e              state_s;
  logic [K_W-1:0]          k_r;
  logic                    capture_s;
  logic                    mac_en_s;
  logic                    round_s;
  logic signed [31:0]      cap_l_r [NUM_BANDS];
  logic signed [31:0]      cap_r_r [NUM_BANDS];
  logic [15:0]             gain_r  [NUM_BANDS];
  logic [15:0]             snap_r  [NUM_BANDS];
  logic signed [31:0]      x_s;
  logic signed [15:0]      g_s;
  logic signed [ACC_W-1:0] acc_l_s;
  logic signed [ACC_W-1:0] acc_r_s;
  logic [23:0]             l_out_r;
  logic [23:0]             r_out_r;
  logic                    out_valid_r;
  logic                    busy_r;
  logic                    overrun_r;
  logic                    unused_s;

  // Only the audio-scale slice of each band word reaches the multiplier.
  assign unused_s = ^{l_band_in, r_band_in};

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and per-cycle datapath controls; audio_en low aborts to IDLE.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    mac_en_s  = 1'b0;
    round_s   = 1'b0;
    if (!audio_en) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_s   = MAC;
            capture_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        MAC: begin
          mac_en_s = 1'b1;
          if (k_r == K_LAST) begin
            state_s = DRAIN;
          end else begin
            state_s = MAC;
          end
        end
        DRAIN:   state_s = ROUND;
        ROUND: begin
          state_s = OUT;
          round_s = 1'b1;
        end
        OUT:     state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Even k selects the left band k/2, odd k the right band.
  always_comb begin
    x_s = 32'sd0;
    g_s = 16'sd0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (K_W'(b) == (k_r >> 1)) begin
        x_s = k_r[0] ? cap_r_r[b] : cap_l_r[b];
        g_s = snap_r[b];
      end else begin
        x_s = x_s;
        g_s = g_s;
      end
    end
  end

  // MAC step counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      k_r <= '0;
    end else if (capture_s) begin
      k_r <= '0;
    end else if (mac_en_s) begin
      k_r <= k_r + K_W'(1);
    end
  end

  // Live gain registers; out-of-range indices match no band and are dropped.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (!reset_n) begin
        gain_r[b] <= GAIN_UNITY;
      end else if (gain_wr_en && (32'(gain_select) == b)) begin
        gain_r[b] <= {gain_wr_msb, gain_wr_lsb};
      end
    end
  end

  // Band capture and gain snapshot, so mid-mix gain writes wait for the next sample.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (!reset_n) begin
        cap_l_r[b] <= 32'sd0;
        cap_r_r[b] <= 32'sd0;
        snap_r[b]  <= GAIN_UNITY;
      end else if (capture_s) begin
        cap_l_r[b] <= l_band_in[b*48+BAND_SHIFT +: 32];
        cap_r_r[b] <= r_band_in[b*48+BAND_SHIFT +: 32];
        snap_r[b]  <= gain_r[b];
      end
    end
  end

  eq_mix_mac u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (capture_s),
    .en      (mac_en_s),
    .sel_lr  (k_r[0]),
    .x       (x_s),
    .gain    (g_s),
    .acc_l   (acc_l_s),
    .acc_r   (acc_r_s)
  );

  // Output samples and strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      l_out_r     <= 24'h000000;
      r_out_r     <= 24'h000000;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (round_s) begin
        l_out_r <= mute ? 24'h000000 : sat_round24(acc_l_s, GAIN_FRAC);
        r_out_r <= mute ? 24'h000000 : sat_round24(acc_r_s, GAIN_FRAC);
      end
      out_valid_r <= round_s;
      busy_r      <= (state_s != IDLE);
    end
  end

  // Sticky overrun; clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun_r <= 1'b0;
    end else if (overrun_clr) begin
      overrun_r <= 1'b0;
    end else if (in_valid && audio_en && (state_r != IDLE)) begin
      overrun_r <= 1'b1;
    end
  end

  assign l_data_out = l_out_r;
  assign r_data_out = r_out_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed self-checking bench for eq_band_mixer with hand-computed expected samples.
module tb_eq_band_mixer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         audio_en;
  logic         in_valid;
  logic [191:0] l_band_in;
  logic [191:0] r_band_in;
  logic         gain_wr_en;
  logic [1:0]   gain_select;
  logic [7:0]   gain_wr_msb;
  logic [7:0]   gain_wr_lsb;
  logic         mute;
  logic         overrun_clr;
  logic [23:0]  l_data_out;
  logic [23:0]  r_data_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int          ov_cyc, ov_cnt, busy_cnt;
  logic [23:0] l_got, r_got;

  eq_band_mixer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .audio_en    (audio_en),
    .in_valid    (in_valid),
    .l_band_in   (l_band_in),
    .r_band_in   (r_band_in),
    .gain_wr_en  (gain_wr_en),
    .gain_select (gain_select),
    .gain_wr_msb (gain_wr_msb),
    .gain_wr_lsb (gain_wr_lsb),
    .mute        (mute),
    .overrun_clr (overrun_clr),
    .l_data_out  (l_data_out),
    .r_data_out  (r_data_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [47:0] lv, input logic [47:0] rv);
    l_band_in = {4{lv}};
    r_band_in = {4{rv}};
  endtask

  task automatic write_gain(input logic [1:0] idx, input logic [15:0] val);
    gain_wr_en  = 1'b1;
    gain_select = idx;
    gain_wr_msb = val[15:8];
    gain_wr_lsb = val[7:0];
    tick();
    gain_wr_en  = 1'b0;
  endtask

  // One in_valid at cycle 0, then observe cycles 1..20 with optional mid-mix events.
  task automatic do_mix(input int second_at, input int wr_at, input logic [15:0] wr_val,
                        input int rst_at, input int off_at,
                        output int oc, output int on, output int bc,
                        output logic [23:0] lg, output logic [23:0] rg);
    oc = 0; on = 0; bc = 0; lg = 24'h0; rg = 24'h0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (out_valid) begin
        on++;
        if (oc == 0) oc = c;
        lg = l_data_out;
        rg = r_data_out;
      end
      if (busy) bc++;
      if (c == second_at) begin
        in_valid  = 1'b1;
        l_band_in = ~l_band_in;
        r_band_in = ~r_band_in;
      end
      if (c == wr_at) begin
        gain_wr_en  = 1'b1;
        gain_select = 2'd0;
        gain_wr_msb = wr_val[15:8];
        gain_wr_lsb = wr_val[7:0];
      end
      if (c == rst_at) reset_n = 1'b0;
      if (c == off_at) audio_en = 1'b0;
      tick();
      in_valid   = 1'b0;
      gain_wr_en = 1'b0;
      reset_n    = 1'b1;
      audio_en   = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; audio_en = 1'b1; in_valid = 1'b0; gain_wr_en = 1'b0;
    gain_select = 2'd0; gain_wr_msb = 8'h00; gain_wr_lsb = 8'h00;
    mute = 1'b0; overrun_clr = 1'b0;
    set_all(48'h0, 48'h0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    total_cnt++; if (l_data_out !== 24'h0) $display("FAIL reset_l got %h want 000000", l_data_out); else pass_cnt++;
    total_cnt++; if (r_data_out !== 24'h0) $display("FAIL reset_r got %h want 000000", r_data_out); else pass_cnt++;
    total_cnt++; if ({out_valid, busy, overrun} !== 3'b000) $display("FAIL reset_flags got %b want 000", {out_valid, busy, overrun}); else pass_cnt++;
  endtask

  task automatic test_unity(input string tag);
    set_all(48'h0, 48'h0);
    l_band_in[47:0] = 48'sd3276800;
    r_band_in[47:0] = -48'sd3276800;
    do_mix(0, 0, 16'h0, 0, 0, ov_cyc, ov_cnt, busy_cnt, l_got, r_got);
    total_cnt++; if (ov_cyc !== 11 || ov_cnt !== 1) $display("FAIL %s_latency got cyc %0d cnt %0d want 11/1", tag, ov_cyc, ov_cnt); else pass_cnt++;
    total_cnt++; if (l_got !== 24'h000064) $display("FAIL %s_l got %h want 000064", tag, l_got); else pass_cnt++;
    total_cnt++; if (r_got !== 24'hFFFF9C) $display("FAIL %s_r got %h want ffff9c", tag, r_got); else pass_cnt++;
    total_cnt++; if (l_data_out !== 24'h000064) $display("FAIL %s_hold got %h want 000064", tag, l_data_out); else pass_cnt++;
  endtask

  task automatic test_half_gain();
    for (int b = 0; b < 4; b++) write_gain(2'(b), 16'h2000);
    set_all(48'sd32768000, 48'sd32768000);
    do_mix(0, 0, 16'h0, 0, 0, ov_cyc, ov_cnt, busy_cnt, l_got, r_got);
    total_cnt++; if (l_got !== 24'h0007D0 || r_got !== 24'h0007D0) $display("FAIL half_gain got %h/%h want 0007d0/0007d0", l_got, r_got); else pass_cnt++;
    total_cnt++; if (busy_cnt !== 11) $display("FAIL half_gain_busy got %0d want 11", busy_cnt); else pass_cnt++;
  endtask

  task automatic test_audio_en();
    do_mix(0, 0, 16'h0, 0, 4, ov_cyc, ov_cnt, busy_cnt, l_got, r_got);
    total_cnt++; if (ov_cnt !== 0 || busy_cnt !== 4) $display("FAIL audio_off got ov %0d busy %0d want 0/4", ov_cnt, busy_cnt); else pass_cnt++;
    total_cnt++; if (l_data_out !== 24'h0007D0) $display("FAIL audio_off_hold got %h want 0007d0", l_data_out); else pass_cnt++;
  endtask

  task automatic test_abort_reset();
    do_mix(0, 0, 16'h0, 5, 0, ov_cyc, ov_cnt, busy_cnt, l_got, r_got);
    total_cnt++; if (ov_cnt !== 0) $display("FAIL rst_abort_ov got %0d want 0", ov_cnt); else pass_cnt++;
    total_cnt++; if (busy_cnt !== 5 || busy !== 1'b0) $display("FAIL rst_abort_busy got %0d/%b want 5/0", busy_cnt, busy); else pass_cnt++;
    test_unity("after_rst");
  endtask

  task automatic test_saturation();
    set_all(48'h003FFFFF8000, 48'h0);
    do_mix(0, 0, 16'h0, 0, 0, ov_cyc, ov_cnt, busy_cnt, l_got, r_got);
    total_cnt++; if (l_got !== 24'h7FFFFF) $display("FAIL sat_pos got %h want 7fffff", l_got); else pass_cnt++;
    set_all(48'hFFC000000000, 48'h0);
    do_mix(0, 0, 16'h0, 0, 0, ov_cyc, ov_cnt, busy_cnt, l_got, r_got);
    total_cnt++; if (l_got !== 24'h800000) $display("FAIL sat_neg got %h want 800000", l_got); else pass_cnt++;
  endtask

  task automatic test_overrun();
    total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_pre got %b want 0", overrun); else pass_cnt++;
    set_all(48'sd3276800, 48'sd3276800);
    do_mix(3, 0, 16'h0, 0, 0, ov_cyc, ov_cnt, busy_cnt, l_got, r_got);
    total_cnt++; if (ov_cyc !== 11 || ov_cnt !== 1) $display("FAIL ovr_single got cyc %0d cnt %0d want 11/1", ov_cyc, ov_cnt); else pass_cnt++;
    total_cnt++; if (l_got !== 24'h000190 || r_got !== 24'h000190) $display("FAIL ovr_data got %h/%h want 000190/000190", l_got, r_got); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun); else pass_cnt++;
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clr got %b want 0", overrun); else pass_cnt++;
  endtask

  task automatic test_gain_snapshot_mute();
    set_all(48'h0, 48'h0);
    l_band_in[47:0] = 48'sd3276800;
    do_mix(0, 4, 16'h0000, 0, 0, ov_cyc, ov_cnt, busy_cnt, l_got, r_got);
    total_cnt++; if (l_got !== 24'h000064) $display("FAIL snap_old got %h want 000064", l_got); else pass_cnt++;
    do_mix(0, 0, 16'h0, 0, 0, ov_cyc, ov_cnt, busy_cnt, l_got, r_got);
    total_cnt++; if (l_got !== 24'h000000) $display("FAIL snap_new got %h want 000000", l_got); else pass_cnt++;
    write_gain(2'd0, 16'h4000);
    mute = 1'b1;
    do_mix(0, 0, 16'h0, 0, 0, ov_cyc, ov_cnt, busy_cnt, l_got, r_got);
    mute = 1'b0;
    total_cnt++; if (ov_cyc !== 11) $display("FAIL mute_latency got %0d want 11", ov_cyc); else pass_cnt++;
    total_cnt++; if (l_got !== 24'h0 || r_got !== 24'h0) $display("FAIL mute_data got %h/%h want 000000/000000", l_got, r_got); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_unity("unity");
    test_half_gain();
    test_audio_en();
    test_abort_reset();
    test_saturation();
    test_overrun();
    test_gain_snapshot_mute();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
